// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encodings, the default reset PC, the word transfer size and PC helpers.
package if_fetch_ctrl_pkg;

   // One-hot fetch FSM states.
   localparam logic [2:0] ST_REQ  = 3'b001;
   localparam logic [2:0] ST_WAIT = 3'b010;
   localparam logic [2:0] ST_HOLD = 3'b100;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;
   localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

   // Every fetch address is word aligned, whatever the source.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Sequential successor; wraps naturally from 32'hFFFF_FFFC to zero.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return word_align(pc + 32'd4);
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_inst_buf.sv
// if_inst_buf: holds the PC/instruction pair presented to decode while
// decode is stalled. Clear has priority over load.
module if_inst_buf (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic [31:0] pc,
   output logic [31:0] inst
);

   // Capture a returned instruction, or drop it when fetch is redirected.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pc   <= 32'h0;
         inst <= 32'h0;
      end else if (clear) begin
         pc   <= 32'h0;
         inst <= 32'h0;
      end else if (load) begin
         pc   <= load_pc;
         inst <= load_inst;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch stage driving an SRAM-like port of the
// AXI bridge with at most one request outstanding. Redirects from execute
// either retarget the pending request or cancel the in-flight one.
// Optional macro FETCH_BYPASS_EN presents returned data to decode in the
// data_ok cycle instead of always going through the holding buffer.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ds_allowin,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   logic [2:0]  state;
   logic [31:0] fetch_pc;
   logic        cancel;
   logic        run;
   logic [31:0] buf_pc;
   logic [31:0] buf_inst;

   logic is_req, is_wait, is_hold;
   logic req_fire, take_data, bypass_fire, buf_load, buf_clear;

   assign is_req  = (state == ST_REQ);
   assign is_wait = (state == ST_WAIT);
   assign is_hold = (state == ST_HOLD);

   // Instruction port is read-only, word sized.
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = INST_SIZE_WORD;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;

   // Request is held off until the first clock edge out of reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) run <= 1'b0;
      else          run <= 1'b1;
   end

   // Handshake qualifiers and buffer control.
   always_comb begin
      inst_sram_req  = is_req & run;
      inst_sram_addr = inst_sram_req ? fetch_pc : 32'h0;
      req_fire       = inst_sram_req & inst_sram_addr_ok;
      take_data      = is_wait & inst_sram_data_ok & ~cancel & ~br_taken;
`ifdef FETCH_BYPASS_EN
      bypass_fire    = take_data & ds_allowin;
`else
      bypass_fire    = 1'b0;
`endif
      buf_load       = take_data & ~bypass_fire;
      buf_clear      = is_hold & br_taken;
   end

   // Presentation to decode; a redirect in HOLD suppresses the buffer.
   always_comb begin
`ifdef FETCH_BYPASS_EN
      fs_valid = (is_hold & ~br_taken) | take_data;
      fs_pc    = take_data ? fetch_pc        : buf_pc;
      fs_inst  = take_data ? inst_sram_rdata : buf_inst;
`else
      fs_valid = is_hold & ~br_taken;
      fs_pc    = buf_pc;
      fs_inst  = buf_inst;
`endif
   end

   // Fetch FSM: PC update, state transitions and cancel tracking.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_REQ;
         fetch_pc <= word_align(RESET_PC);
         cancel   <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               if (br_taken) fetch_pc <= word_align(br_target);
               if (req_fire) begin
                  state <= ST_WAIT;
                  // Accepted address is stale once redirected.
                  if (br_taken) cancel <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (inst_sram_data_ok) begin
                  cancel <= 1'b0;
                  if (br_taken) fetch_pc <= word_align(br_target);
                  if (take_data) begin
                     if (bypass_fire) begin
                        fetch_pc <= seq_pc(fetch_pc);
                        state    <= ST_REQ;
                     end else begin
                        state <= ST_HOLD;
                     end
                  end else begin
                     state <= ST_REQ;
                  end
               end else if (br_taken) begin
                  fetch_pc <= word_align(br_target);
                  cancel   <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (br_taken) begin
                  fetch_pc <= word_align(br_target);
                  state    <= ST_REQ;
               end else if (ds_allowin) begin
                  fetch_pc <= seq_pc(buf_pc);
                  state    <= ST_REQ;
               end
            end
            default: begin
               state  <= ST_REQ;
               cancel <= 1'b0;
            end
         endcase
      end
   end

   if_inst_buf u_inst_buf (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .load      (buf_load),
      .clear     (buf_clear),
      .load_pc   (fetch_pc),
      .load_inst (inst_sram_rdata),
      .pc        (buf_pc),
      .inst      (buf_inst)
   );

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h1C00_0000, first fetch address after reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: aclk  in  1  clock; aresetn  in  1  async active-low reset.
REQ-003 SHALL have: br_taken  in  1  redirect request from execute, valid one cycle.
REQ-004 SHALL have: br_target  in  32  redirect address.
REQ-005 SHALL have: ds_allowin  in  1  decode stage ready.
REQ-006 SHALL have: fs_valid  out  1  instruction valid to decode.
REQ-007 SHALL have: fs_pc  out  32  PC of presented instruction.
REQ-008 SHALL have: fs_inst  out  32  presented instruction.
REQ-009 SHALL have: inst_sram_req  out  1, inst_sram_wr  out  1, inst_sram_size  out  2, inst_sram_addr  out  32, inst_sram_wstrb  out  4, inst_sram_wdata  out  32, SRAM-like request to the AXI bridge instruction port.
REQ-010 SHALL have: inst_sram_addr_ok  in  1, inst_sram_data_ok  in  1, inst_sram_rdata  in  32, bridge responses; rdata valid in the data_ok cycle.

Function
REQ-011 SHALL tie inst_sram_wr=0, inst_sram_size=2'b10, inst_sram_wstrb=0, inst_sram_wdata=0.
REQ-012 SHALL implement states REQ, WAIT, HOLD (one-hot); at most one request outstanding.
REQ-013 REQ: inst_sram_req=1, inst_sram_addr=fetch_pc; addr_ok -> WAIT.
REQ-014 WAIT: inst_sram_req=0; data_ok with cancel=0 -> capture rdata/fetch_pc into buffer, -> HOLD; data_ok with cancel=1 -> clear cancel, -> REQ, nothing presented.
REQ-015 HOLD: fs_valid=1, fs_pc/fs_inst from buffer; fs_valid&&ds_allowin -> fetch_pc<=fs_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> REQ.
REQ-016 br_taken in REQ without addr_ok: fetch_pc<=br_target, stay REQ (address may change while req high).
REQ-017 br_taken in REQ with addr_ok, or in WAIT before data_ok: fetch_pc<=br_target, set cancel; in-flight data discarded.
REQ-018 br_taken in WAIT coinciding with data_ok: data discarded, cancel stays 0, fetch_pc<=br_target, -> REQ.
REQ-019 br_taken in HOLD: buffer dropped, fs_valid=0 that cycle, fetch_pc<=br_target, -> REQ; br_taken has priority over ds_allowin handshake.
REQ-020 SHALL force fetch_pc[1:0]=2'b00 on every load.
REQ-021 Minimum latency: addr_ok in first REQ cycle, data_ok one cycle later -> fs_valid on the following cycle.

Reset
REQ-022 While aresetn=0: state=REQ, fetch_pc=RESET_PC, cancel=0, buffer=0, fs_valid=0, fs_pc=0, fs_inst=0, inst_sram_req=0.
REQ-023 inst_sram_req SHALL first assert in the first rising edge after aresetn deasserts; reset mid-transaction abandons it without waiting for data_ok.

Configuration
REQ-024 Macro FETCH_BYPASS_EN: defined -> on non-cancelled data_ok, fs_valid=1 same cycle with fs_inst=inst_sram_rdata; if ds_allowin, fetch_pc<=pc+4 and -> REQ (HOLD skipped), else capture and -> HOLD. Undefined -> always via HOLD (REQ-014).

Structure
REQ-025 Shared package SHALL hold state encodings, default RESET_PC, INST_SIZE_WORD=2'b10.
REQ-026 One sub-module if_inst_buf: PC/instruction holding register with load/clear.

Verification
REQ-027 Reset release, addr_ok same cycle, data_ok one cycle later, ds_allowin=1 -> fs_valid with fs_pc=32'h1C00_0000, next request addr 32'h1C00_0004.
REQ-028 ds_allowin=0 for 5 cycles in HOLD -> fs_valid/fs_pc/fs_inst stable, inst_sram_req=0 throughout.
REQ-029 br_taken target 32'h1C00_0100 in WAIT -> returned data never presented; next request addr 32'h1C00_0100.
REQ-030 br_taken target 32'h1C00_0203 with addr_ok -> request addr 32'h1C00_0200, one discarded data_ok.
REQ-031 fs_pc=32'hFFFF_FFFC handshake -> next request addr 32'h0000_0000.
REQ-032 aresetn low during WAIT -> all outputs zero, restart fetch at RESET_PC.
